multicycle_control_unit: RTL and testbench

- Parametrised multi-cycle RV32I control FSM. It succeeds the single-cycle combinational ControlUnit.
- Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and handshakes with memory via MemReady.
- Adds jump, upper-immediate and illegal-opcode trap handling, plus an optional memory-wait timeout.
- Drives all datapath mux selects and write strobes of the multi-cycle core.

---
 rtl/multicycle_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// every datapath select and write strobe, with jump/upper-imm, trap and memory-wait timeout.
module multicycle_control_unit #(
  parameter bit SUPPORT_JUMP  = 1'b1,
  parameter bit SUPPORT_UPPER = 1'b1,
  parameter bit TRAP_STICKY   = 1'b1,
  parameter int MEM_TIMEOUT   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Inst,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       Illegal,
  output logic [2:0] State
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_BRANCH = 3'd5,
    S_JUMP   = 3'd6,
    S_TRAP   = 3'd7
  } state_e;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_LW    = 5'b00000;
  localparam logic [4:0] OP_SW    = 5'b01000;
  localparam logic [4:0] OP_BEQ   = 5'b11000;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;

  state_e          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [CW-1:0]   wait_q, wait_d;
  logic            waiting;
  logic            timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  // The wait counter holds the number of earlier stalled cycles; this cycle is the N-th when it reads N-1.
  assign waiting     = ((state_q == S_FETCH) || (state_q == S_MEM)) && !MemReady;
  assign timeout_hit = (MEM_TIMEOUT > 0) && waiting && ((int'(wait_q) + 1) >= MEM_TIMEOUT);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    case (state_q)
      S_FETCH: begin
        if (MemReady)         state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_DECODE: begin
        op_d = Inst;
        case (Inst)
          OP_R, OP_I, OP_LW, OP_SW: state_d = S_EXEC;
          OP_LUI, OP_AUIPC: begin
            if (SUPPORT_UPPER) state_d = S_EXEC;
            else               state_d = S_TRAP;
          end
          OP_BEQ: state_d = S_BRANCH;
          OP_JAL, OP_JALR: begin
            if (SUPPORT_JUMP) state_d = S_JUMP;
            else              state_d = S_TRAP;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        if ((op_q == OP_LW) || (op_q == OP_SW)) state_d = S_MEM;
        else                                    state_d = S_WB;
      end
      S_MEM: begin
        if (MemReady) begin
          if (op_q == OP_LW) state_d = S_WB;
          else               state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end
      end
      S_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP: begin
        if (!TRAP_STICKY) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if ((MEM_TIMEOUT > 0) && waiting && (state_d == state_q)) wait_d = wait_q + CW'(1);
  end

  assign State = state_q;

  // Outputs are forced low while rst_n is held, so FETCH strobes only show once reset is released.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 2'b00;
    RegWrite = 1'b0;
    ALUSrcA  = 2'b00;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    Branch   = 1'b0;
    PCSrc    = 2'b00;
    Illegal  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = MemReady;
          IRWrite = MemReady;
        end
        S_DECODE: ALUSrcB = 2'b10;
        S_EXEC: begin
          case (op_q)
            OP_R:     begin ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUOp = 2'b10; end
            OP_I:     begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUOp = 2'b10; end
            OP_LW,
            OP_SW:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; end
            OP_LUI:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b10; end
            OP_AUIPC: begin ALUSrcA = 2'b11; ALUSrcB = 2'b10; end
            default:  ;
          endcase
        end
        S_MEM: begin
          IorD     = 1'b1;
          MemRead  = (op_q == OP_LW);
          MemWrite = (op_q == OP_SW);
        end
        S_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (op_q == OP_LW) ? 2'b01 : 2'b00;
        end
        S_BRANCH: begin
          ALUSrcA = 2'b01;
          ALUOp   = 2'b01;
          Branch  = 1'b1;
          PCSrc   = 2'b01;
        end
        S_JUMP: begin
          RegWrite = 1'b1;
          MemtoReg = 2'b10;
          PCWrite  = 1'b1;
          if (op_q == OP_JALR) begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
          end else begin
            PCSrc = 2'b01;
          end
        end
        S_TRAP: Illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: three parameter variants share stimulus,
// a driver queues hand-computed expected output vectors and a negedge monitor compares them.
module tb_multicycle_control_unit;

  localparam int VW = 21;

  logic       clk;
  logic       rst_n;
  logic [4:0] Inst;
  logic       MemReady;

  // Per instance: 0 = defaults, 1 = SUPPORT_JUMP=0, 2 = TRAP_STICKY=0 with MEM_TIMEOUT=4
  logic       pcw [3], irw [3], iord [3], mr [3], mw [3], rw [3], br [3], ill [3];
  logic [1:0] m2r [3], sa [3], sb [3], aop [3], pcs [3];
  logic [2:0] st [3];
  logic [VW-1:0] act [3];

  logic [VW+1:0] exp_q [$];
  string         tag_q [$];
  int            n_checks;
  int            n_errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_unit u_dut_a (
    .clk(clk), .rst_n(rst_n), .Inst(Inst), .MemReady(MemReady),
    .PCWrite(pcw[0]), .IRWrite(irw[0]), .IorD(iord[0]), .MemRead(mr[0]), .MemWrite(mw[0]),
    .MemtoReg(m2r[0]), .RegWrite(rw[0]), .ALUSrcA(sa[0]), .ALUSrcB(sb[0]), .ALUOp(aop[0]),
    .Branch(br[0]), .PCSrc(pcs[0]), .Illegal(ill[0]), .State(st[0])
  );

  multicycle_control_unit #(.SUPPORT_JUMP(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .Inst(Inst), .MemReady(MemReady),
    .PCWrite(pcw[1]), .IRWrite(irw[1]), .IorD(iord[1]), .MemRead(mr[1]), .MemWrite(mw[1]),
    .MemtoReg(m2r[1]), .RegWrite(rw[1]), .ALUSrcA(sa[1]), .ALUSrcB(sb[1]), .ALUOp(aop[1]),
    .Branch(br[1]), .PCSrc(pcs[1]), .Illegal(ill[1]), .State(st[1])
  );

  multicycle_control_unit #(.TRAP_STICKY(1'b0), .MEM_TIMEOUT(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .Inst(Inst), .MemReady(MemReady),
    .PCWrite(pcw[2]), .IRWrite(irw[2]), .IorD(iord[2]), .MemRead(mr[2]), .MemWrite(mw[2]),
    .MemtoReg(m2r[2]), .RegWrite(rw[2]), .ALUSrcA(sa[2]), .ALUSrcB(sb[2]), .ALUOp(aop[2]),
    .Branch(br[2]), .PCSrc(pcs[2]), .Illegal(ill[2]), .State(st[2])
  );

  for (genvar g = 0; g < 3; g++) begin : g_pack
    assign act[g] = {st[g], pcw[g], irw[g], iord[g], mr[g], mw[g], m2r[g], rw[g],
                     sa[g], sb[g], aop[g], br[g], pcs[g], ill[g]};
  end

  function automatic logic [VW-1:0] pk(
    input logic [2:0] s, input logic pw, input logic iw, input logic id, input logic rd,
    input logic wr, input logic [1:0] m2, input logic rwr, input logic [1:0] a,
    input logic [1:0] b, input logic [1:0] op, input logic bra, input logic [1:0] ps,
    input logic il);
    return {s, pw, iw, id, rd, wr, m2, rwr, a, b, op, bra, ps, il};
  endfunction

  function automatic logic [VW-1:0] v_f(input logic r);
    return pk(3'd0, r, r, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic logic [VW-1:0] v_d();
    return pk(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic logic [VW-1:0] v_e(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op);
    return pk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, a, b, op, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic logic [VW-1:0] v_m(input logic lw);
    return pk(3'd3, 1'b0, 1'b0, 1'b1, lw, !lw, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic logic [VW-1:0] v_w(input logic lw);
    return pk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, lw}, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b0);
  endfunction
  function automatic logic [VW-1:0] v_b();
    return pk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd1, 2'd0, 2'd1, 1'b1, 2'd1, 1'b0);
  endfunction
  function automatic logic [VW-1:0] v_j(input logic jalr);
    if (jalr) return pk(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd1, 2'd2, 2'd0, 1'b0, 2'd0, 1'b0);
    return pk(3'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd1, 1'b0);
  endfunction
  function automatic logic [VW-1:0] v_t();
    return pk(3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 1'b1);
  endfunction

  task automatic expect_v(input logic [1:0] sel, input logic [VW-1:0] e, input string tag);
    exp_q.push_back({sel, e});
    tag_q.push_back(tag);
  endtask

  // One clock cycle: inputs change just after the rising edge, expectation for this cycle is queued.
  task automatic cyc(input logic r, input logic [4:0] inst, input logic rdy,
                     input logic [1:0] sel, input logic [VW-1:0] e, input string tag);
    @(posedge clk);
    #1;
    rst_n    = r;
    Inst     = inst;
    MemReady = rdy;
    expect_v(sel, e, tag);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [VW+1:0] ent;
      string         tg;
      ent = exp_q.pop_front();
      tg  = tag_q.pop_front();
      n_checks++;
      if (act[ent[VW+1:VW]] !== ent[VW-1:0]) begin
        n_errors++;
        $display("FAIL %s: dut%0d got %h expected %h", tg, ent[VW+1:VW], act[ent[VW+1:VW]], ent[VW-1:0]);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    Inst     = 5'b0;
    MemReady = 1'b0;

    // Reset state on all three variants
    cyc(1'b0, 5'b00000, 1'b1, 2'd0, '0, "reset_a");
    expect_v(2'd1, '0, "reset_b");
    expect_v(2'd2, '0, "reset_c");

    // Back-to-back R, LW, SW with MemReady tied high
    cyc(1'b1, 5'b01100, 1'b1, 2'd0, v_f(1'b1), "r_fetch");
    cyc(1'b1, 5'b01100, 1'b1, 2'd0, v_d(), "r_decode");
    cyc(1'b1, 5'b00000, 1'b1, 2'd0, v_e(2'd1, 2'd0, 2'd2), "r_exec");
    cyc(1'b1, 5'b00000, 1'b1, 2'd0, v_w(1'b0), "r_wb");
    cyc(1'b1, 5'b00000, 1'b1, 2'd0, v_f(1'b1), "lw_fetch");
    cyc(1'b1, 5'b00000, 1'b1, 2'd0, v_d(), "lw_decode");
    cyc(1'b1, 5'b00000, 1'b1, 2'd0, v_e(2'd1, 2'd2, 2'd0), "lw_exec");
    cyc(1'b1, 5'b00000, 1'b1, 2'd0, v_m(1'b1), "lw_mem");
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_w(1'b1), "lw_wb");
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_f(1'b1), "sw_fetch");
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_d(), "sw_decode");
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_e(2'd1, 2'd2, 2'd0), "sw_exec");
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_m(1'b0), "sw_mem");

    // LW stalled three cycles in MEM while Inst changes to BEQ
    cyc(1'b1, 5'b00000, 1'b1, 2'd0, v_f(1'b1), "lws_fetch");
    cyc(1'b1, 5'b00000, 1'b1, 2'd0, v_d(), "lws_decode");
    cyc(1'b1, 5'b11000, 1'b1, 2'd0, v_e(2'd1, 2'd2, 2'd0), "lws_exec");
    cyc(1'b1, 5'b11000, 1'b0, 2'd0, v_m(1'b1), "lws_mem1");
    cyc(1'b1, 5'b11000, 1'b0, 2'd0, v_m(1'b1), "lws_mem2");
    cyc(1'b1, 5'b11000, 1'b0, 2'd0, v_m(1'b1), "lws_mem3");
    cyc(1'b1, 5'b11000, 1'b1, 2'd0, v_m(1'b1), "lws_mem4");
    cyc(1'b1, 5'b11000, 1'b1, 2'd0, v_w(1'b1), "lws_wb");

    // I-ALU, LUI, AUIPC execute selects
    cyc(1'b1, 5'b00100, 1'b1, 2'd0, v_f(1'b1), "i_fetch");
    cyc(1'b1, 5'b00100, 1'b1, 2'd0, v_d(), "i_decode");
    cyc(1'b1, 5'b11111, 1'b1, 2'd0, v_e(2'd1, 2'd2, 2'd2), "i_exec");
    cyc(1'b1, 5'b11111, 1'b1, 2'd0, v_w(1'b0), "i_wb");
    cyc(1'b1, 5'b01101, 1'b1, 2'd0, v_f(1'b1), "lui_fetch");
    cyc(1'b1, 5'b01101, 1'b1, 2'd0, v_d(), "lui_decode");
    cyc(1'b1, 5'b01101, 1'b1, 2'd0, v_e(2'd2, 2'd2, 2'd0), "lui_exec");
    cyc(1'b1, 5'b01101, 1'b1, 2'd0, v_w(1'b0), "lui_wb");
    cyc(1'b1, 5'b00101, 1'b1, 2'd0, v_f(1'b1), "auipc_fetch");
    cyc(1'b1, 5'b00101, 1'b1, 2'd0, v_d(), "auipc_decode");
    cyc(1'b1, 5'b00101, 1'b1, 2'd0, v_e(2'd3, 2'd2, 2'd0), "auipc_exec");
    cyc(1'b1, 5'b00101, 1'b1, 2'd0, v_w(1'b0), "auipc_wb");

    // BEQ, JAL, JALR three-cycle paths, then a FETCH stall
    cyc(1'b1, 5'b11000, 1'b1, 2'd0, v_f(1'b1), "beq_fetch");
    cyc(1'b1, 5'b11000, 1'b1, 2'd0, v_d(), "beq_decode");
    cyc(1'b1, 5'b11011, 1'b1, 2'd0, v_b(), "beq_branch");
    cyc(1'b1, 5'b11011, 1'b1, 2'd0, v_f(1'b1), "jal_fetch");
    cyc(1'b1, 5'b11011, 1'b1, 2'd0, v_d(), "jal_decode");
    cyc(1'b1, 5'b11001, 1'b1, 2'd0, v_j(1'b0), "jal_jump");
    cyc(1'b1, 5'b11001, 1'b1, 2'd0, v_f(1'b1), "jalr_fetch");
    cyc(1'b1, 5'b11001, 1'b1, 2'd0, v_d(), "jalr_decode");
    cyc(1'b1, 5'b11001, 1'b1, 2'd0, v_j(1'b1), "jalr_jump");
    cyc(1'b1, 5'b11001, 1'b0, 2'd0, v_f(1'b0), "fetch_stall1");
    cyc(1'b1, 5'b11001, 1'b0, 2'd0, v_f(1'b0), "fetch_stall2");

    // Reset asserted in the middle of a stalled SW access
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_f(1'b1), "swr_fetch");
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_d(), "swr_decode");
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_e(2'd1, 2'd2, 2'd0), "swr_exec");
    cyc(1'b1, 5'b01000, 1'b0, 2'd0, v_m(1'b0), "swr_mem");
    cyc(1'b0, 5'b01000, 1'b0, 2'd0, '0, "swr_reset_mid_mem");
    cyc(1'b1, 5'b01000, 1'b1, 2'd0, v_f(1'b1), "swr_post_reset");

    // SUPPORT_JUMP=0: JAL traps and the sticky trap persists
    cyc(1'b0, 5'b00000, 1'b1, 2'd1, '0, "nj_reset");
    cyc(1'b1, 5'b11011, 1'b1, 2'd1, v_f(1'b1), "nj_fetch");
    cyc(1'b1, 5'b11011, 1'b1, 2'd1, v_d(), "nj_decode");
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, (i % 2 == 0) ? 5'b01100 : 5'b00000, i[0], 2'd1, v_t(), "nj_trap_sticky");
    end

    // TRAP_STICKY=0: illegal opcode gives a one-cycle trap
    cyc(1'b0, 5'b00000, 1'b1, 2'd2, '0, "ns_reset");
    cyc(1'b1, 5'b11111, 1'b1, 2'd2, v_f(1'b1), "ns_fetch");
    cyc(1'b1, 5'b11111, 1'b1, 2'd2, v_d(), "ns_decode");
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_t(), "ns_trap");

    // MEM_TIMEOUT=4 in FETCH: four stalled cycles trap
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_f(1'b0), "to_fetch_w1");
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_f(1'b0), "to_fetch_w2");
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_f(1'b0), "to_fetch_w3");
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_f(1'b0), "to_fetch_w4");
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_t(), "to_fetch_trap");
    // MemReady on the fourth cycle wins over the timeout
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_f(1'b0), "to_race_w1");
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_f(1'b0), "to_race_w2");
    cyc(1'b1, 5'b11111, 1'b0, 2'd2, v_f(1'b0), "to_race_w3");
    cyc(1'b1, 5'b00000, 1'b1, 2'd2, v_f(1'b1), "to_race_ready");
    cyc(1'b1, 5'b00000, 1'b0, 2'd2, v_d(), "to_race_decode");
    // Timeout also applies to a stalled load in MEM
    cyc(1'b1, 5'b00000, 1'b0, 2'd2, v_e(2'd1, 2'd2, 2'd0), "to_lw_exec");
    cyc(1'b1, 5'b00000, 1'b0, 2'd2, v_m(1'b1), "to_mem_w1");
    cyc(1'b1, 5'b00000, 1'b0, 2'd2, v_m(1'b1), "to_mem_w2");
    cyc(1'b1, 5'b00000, 1'b0, 2'd2, v_m(1'b1), "to_mem_w3");
    cyc(1'b1, 5'b00000, 1'b0, 2'd2, v_m(1'b1), "to_mem_w4");
    cyc(1'b1, 5'b00000, 1'b1, 2'd2, v_t(), "to_mem_trap");
    cyc(1'b1, 5'b00000, 1'b1, 2'd2, v_f(1'b1), "to_mem_refetch");

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
